// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents:
//   state_t        - arbiter FSM encoding (IDLE, ACCESS, DONE)
//   DEF_*          - default core count, address/data widths and memory latency
//   CNT_W          - width of the access down-counter (latencies up to 7 cycles)
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MEM_LAT   = 2;
  localparam int CNT_W         = 3;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req       - request vector, one bit per core
//   last      - index of the previous winner; the search starts one above it
//   grant_oh  - one-hot winner (zero when no request)
//   grant_idx - binary index of the winner (zero when no request)
//   any       - at least one request is pending
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk the cores starting at last+1, wrapping; the first requester wins.
  // k runs 1..N so the previous winner itself is visited last.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores access to one single-port data memory.
// Handshake: a core raises core_req (level) with core_we/core_addr/core_wdata and
// holds it; once selected, core_grant stays high through the transaction and
// core_done pulses for one cycle at the end (with core_rdata valid in that cycle).
// Request inputs are latched at selection and ignored afterwards.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   core_req/we/addr/wdata         - per-core request inputs (packed, core i at slot i)
//   core_grant, core_done          - one-hot owner and completion pulse
//   core_rdata                     - read data, valid while core_done is high
//   mem_en/we/addr/wdata, mem_rdata - single-port memory interface
//   dbg_state                      - current FSM state (state_t encoding)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_LAT   = DEF_MEM_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [NUM_CORES-1:0]        core_done,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [1:0]                  dbg_state
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [NUM_CORES-1:0]   pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  rr_picker #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req       (core_req),
    .last      (last_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_W'(MEM_LAT);
          last_d  = pick_idx;
          grant_d = pick_oh;
          we_d    = core_we[pick_idx];
          addr_d  = core_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = core_wdata[pick_idx*DATA_W +: DATA_W];
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        // Last access cycle: memory data is valid now, capture it for DONE.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          rdata_d = we_q ? '0 : mem_rdata;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= IDX_W'(NUM_CORES - 1);
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory-side outputs are gated by mem_en so the bus is quiet outside ACCESS.
  assign mem_en     = (state_q == ST_ACCESS);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = mem_en ? addr_q : '0;
  assign mem_wdata  = mem_en ? wdata_q : '0;
  assign core_grant = grant_q;
  assign core_done  = (state_q == ST_DONE) ? grant_q : '0;
  assign core_rdata = (state_q == ST_DONE) ? rdata_q : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// multi-core traffic, checked by a scoreboard fed from a transaction-level model.
module tb_dmem_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int IW  = 2;
  localparam int EW  = 28;  // {core[3], we, addr[8], wdata[8], rdata[8]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    core_req, core_we, core_grant, core_done;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_en, mem_we;
  logic [1:0]      dbg_state;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_grant (core_grant),
    .core_done  (core_done),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- memory device ----------------
  // Unwritten words read as addr^B3. Data is only correct in the last access
  // cycle; earlier cycles return the inverted word.
  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hB3;
  endfunction

  logic [DW-1:0] ram [256];
  logic          wrf [256];
  int            en_cnt = 0;
  logic [DW-1:0] dev_word;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) wrf[8'(i)] <= 1'b0;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wrf[mem_addr] <= 1'b1;
    end
    en_cnt <= (mem_en && !rst) ? en_cnt + 1 : 0;
  end

  assign dev_word  = wrf[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  assign mem_rdata = (mem_en && en_cnt == LAT - 1) ? dev_word : ~dev_word;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            done_log[$];
  int            done_cyc[$];
  int            total = 0;
  int            bad = 0;
  int            exp035[3] = '{0, 2, 0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction-level reference: the arbiter is free every LAT+2 cycles after
  // a pick; when free, the first requester after the last winner is served.
  task automatic model_loop();
    int cyc = 0;
    int free_at = 0;
    int last = N - 1;
    int win;
    logic [7:0] mm [256];
    logic [7:0] a, wd, rd;
    logic we;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        free_at = cyc + 1;
        last = N - 1;
        for (int i = 0; i < 256; i++) mm[i] = init_val(8'(i));
      end else if (cyc >= free_at && core_req != '0) begin
        win = -1;
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && core_req[IW'((last + k) % N)]) win = (last + k) % N;
        end
        we = core_we[IW'(win)];
        a  = core_addr[win*AW +: AW];
        wd = core_wdata[win*DW +: DW];
        rd = we ? 8'h00 : mm[a];
        if (we) mm[a] = wd;
        exp_q.push_back({3'(win), we, a, wd, rd});
        last = win;
        free_at = cyc + LAT + 2;
      end
      cyc++;
    end
  endtask

  task automatic monitor_loop();
    logic [EW-1:0] e;
    int mc = 0;
    int di;
    forever begin
      @(posedge clk);
      #1;
      mc++;
      if (core_grant != '0) chk("grant_onehot", $countones(core_grant), 1);
      if (mem_en) begin
        if (exp_q.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 0);
        else begin
          e = exp_q[0];
          chk("mem_addr", 32'(mem_addr), 32'(e[23:16]));
          chk("mem_we", 32'(mem_we), 32'(e[24]));
          if (e[24]) chk("mem_wdata", 32'(mem_wdata), 32'(e[15:8]));
          chk("grant_owner", 32'(core_grant), 32'(1) << e[27:25]);
        end
      end
      if (core_done != '0) begin
        di = 0;
        for (int i = 0; i < N; i++) if (core_done[IW'(i)]) di = i;
        done_log.push_back(di);
        done_cyc.push_back(mc);
        if (exp_q.size() == 0) chk("done_unexpected", 32'(core_done), 0);
        else begin
          e = exp_q.pop_front();
          chk("done_owner", 32'(core_done), 32'(1) << e[27:25]);
          chk("done_rdata", 32'(core_rdata), 32'(e[7:0]));
          chk("done_grant", 32'(core_grant), 32'(core_done));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_fields(input int c, input logic we, input logic [7:0] a, input logic [7:0] wd);
    core_we[IW'(c)]        = we;
    core_addr[c*AW +: AW]  = a;
    core_wdata[c*DW +: DW] = wd;
  endtask

  // One uncontended transaction with cycle-exact checks; optionally the owner
  // drops its request and changes its address after the first access cycle.
  task automatic run_single(input int c, input logic we, input logic [7:0] a,
                            input logic [7:0] wd, input logic [7:0] exp_rd, input bit drop);
    @(negedge clk);
    set_fields(c, we, a, wd);
    core_req[IW'(c)] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < LAT; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("single_grant", 32'(core_grant), 32'(1) << c);
      chk("single_mem_en", 32'(mem_en), 1);
      chk("single_mem_we", 32'(mem_we), 32'(we));
      chk("single_mem_addr", 32'(mem_addr), 32'(a));
      if (we) chk("single_mem_wdata", 32'(mem_wdata), 32'(wd));
      if (drop && k == 0) begin
        @(negedge clk);
        core_req[IW'(c)] = 1'b0;
        core_addr[c*AW +: AW] = ~a;
      end
    end
    @(posedge clk);
    #1;
    chk("single_done", 32'(core_done), 32'(1) << c);
    chk("single_rdata", 32'(core_rdata), 32'(exp_rd));
    chk("single_en_off", 32'(mem_en), 0);
    @(negedge clk);
    core_req[IW'(c)] = 1'b0;
    @(posedge clk);
    #1;
    chk("single_grant_off", 32'(core_grant), 0);
    chk("single_done_off", 32'(core_done), 0);
  endtask

  // Release each core's request when its done arrives (core 0 keeps holding
  // for keep0 of its dones), until want dones are logged and the bus is idle.
  task automatic drain(input int want, input int keep0, input string nm);
    int t = 0;
    int k0 = keep0;
    while ((done_log.size() < want || core_grant != '0) && t < 200) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < N; i++) begin
        if (core_done[IW'(i)]) begin
          if (i == 0 && k0 > 0) k0--;
          else core_req[IW'(i)] = 1'b0;
        end
      end
    end
    if (t >= 200) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic rnd_fields(input int i);
    set_fields(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom()));
  endtask

  task automatic rnd_step();
    for (int i = 0; i < N; i++) begin
      if (core_req[IW'(i)]) begin
        if (core_done[IW'(i)]) begin
          if ($urandom_range(0, 3) == 0) rnd_fields(i);
          else core_req[IW'(i)] = 1'b0;
        end else if (core_grant[IW'(i)]) begin
          if ($urandom_range(0, 7) == 0) core_req[IW'(i)] = 1'b0;
          if ($urandom_range(0, 1) == 1) rnd_fields(i);
        end
      end else if ($urandom_range(0, 4) == 0) begin
        rnd_fields(i);
        core_req[IW'(i)] = 1'b1;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst = 1'b1;
    core_req = '0;
    core_we = '0;
    core_addr = '0;
    core_wdata = '0;
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(core_grant), 0);
    chk("rst_done", 32'(core_done), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rdata", 32'(core_rdata), 0);
    chk("rst_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;

    // single read, single write, owner drops request mid-access
    run_single(1, 1'b0, 8'd22, 8'h00, 8'hA5, 1'b0);
    run_single(3, 1'b1, 8'd23, 8'h3C, 8'h00, 1'b0);
    run_single(2, 1'b0, 8'd40, 8'h00, init_val(8'd40), 1'b1);

    // all four cores at once after reset
    do_reset();
    done_log.delete();
    done_cyc.delete();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      set_fields(i, 1'b0, 8'(100 + i), 8'h00);
      core_req[IW'(i)] = 1'b1;
    end
    drain(4, 0, "all4");
    chk("all4_count", 32'(done_log.size()), 4);
    for (int i = 0; i < 4 && i < done_log.size(); i++) chk("all4_order", 32'(done_log[i]), 32'(i));
    for (int i = 1; i < 4 && i < done_cyc.size(); i++)
      chk("all4_spacing", 32'(done_cyc[i] - done_cyc[i-1]), LAT + 2);

    // core 0 holds, core 2 requests once
    done_log.delete();
    @(negedge clk);
    set_fields(0, 1'b0, 8'd50, 8'h00);
    set_fields(2, 1'b1, 8'd51, 8'h77);
    core_req[0] = 1'b1;
    core_req[2] = 1'b1;
    drain(3, 1, "hold0");
    chk("hold0_count", 32'(done_log.size()), 3);
    for (int i = 0; i < 3 && i < done_log.size(); i++) chk("hold0_order", 32'(done_log[i]), 32'(exp035[i]));

    // reset during the second access cycle aborts; priority restarts at core 0
    @(negedge clk);
    set_fields(1, 1'b0, 8'd7, 8'h00);
    core_req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_in_access", 32'(mem_en), 1);
    @(negedge clk);
    rst = 1'b1;
    set_fields(0, 1'b0, 8'd9, 8'h00);
    core_req[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_mem_en", 32'(mem_en), 0);
    chk("abort_done", 32'(core_done), 0);
    chk("abort_grant", 32'(core_grant), 0);
    @(posedge clk);
    #1;
    chk("rst_override_grant", 32'(core_grant), 0);
    chk("rst_override_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    done_log.delete();
    drain(2, 0, "after_rst");
    chk("after_rst_count", 32'(done_log.size()), 2);
    if (done_log.size() >= 2) begin
      chk("after_rst_first", 32'(done_log[0]), 0);
      chk("after_rst_second", 32'(done_log[1]), 1);
    end

    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      rnd_step();
    end
    @(negedge clk);
    core_req = '0;
    t = 0;
    while ((exp_q.size() != 0 || core_grant != '0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_grant", 32'(core_grant), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
